// File: rtl/ux607_reset_req_seq.sv
// Reset request sequencer: merges sw/wdt/dbg reset requests into a registered,
// minimum-width reset pulse with a downstream hold handshake and a guard window.
module ux607_reset_req_seq #(
   parameter int ASSERT_CYCLES = 20,
   parameter int GUARD_CYCLES  = 4,
   parameter int CNT_W         = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       req_sw,
   input  logic       req_wdt,
   input  logic       req_dbg,
   input  logic       hold_in,
   input  logic       cause_clr,
   output logic       rst_out,
   output logic       busy,
   output logic [2:0] cause,
   output logic [7:0] seq_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ASSERT = 2'd1,
      ST_HOLD   = 2'd2,
      ST_GUARD  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] ASSERT_LAST = CNT_W'(ASSERT_CYCLES - 1);
   localparam logic [CNT_W-1:0] GUARD_LAST  = CNT_W'(GUARD_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       pending_q, pending_d;
   logic [2:0]       cause_q, cause_d;
   logic [7:0]       seq_cnt_q, seq_cnt_d;
   logic             rst_out_q, rst_out_d;
   logic             busy_q, busy_d;
   logic [2:0]       req;
   logic [2:0]       cause_set;

   assign req = {req_dbg, req_wdt, req_sw};

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_ASSERT;
         cnt_q     <= '0;
         pending_q <= '0;
         cause_q   <= '0;
         seq_cnt_q <= '0;
         rst_out_q <= 1'b1;
         busy_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
         cause_q   <= cause_d;
         seq_cnt_q <= seq_cnt_d;
         rst_out_q <= rst_out_d;
         busy_q    <= busy_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pending_d = pending_q;
      seq_cnt_d = seq_cnt_q;
      cause_set = 3'b000;

      case (state_q)
         ST_IDLE: begin
            if ((req | pending_q) != 3'b000) begin
               state_d   = ST_ASSERT;
               cnt_d     = '0;
               cause_set = req | pending_q;
               pending_d = 3'b000;
               if (seq_cnt_q != 8'hFF) begin
                  seq_cnt_d = seq_cnt_q + 8'd1;
               end
            end
         end
         ST_ASSERT: begin
            // Requests here are folded into the running pulse.
            cause_set = req;
            cnt_d     = cnt_q + CNT_ONE;
            if (cnt_q == ASSERT_LAST) begin
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            cause_set = req;
            if (!hold_in) begin
               state_d = ST_GUARD;
               cnt_d   = '0;
            end
         end
         ST_GUARD: begin
            // Requests here are deferred; they launch a new sequence from IDLE.
            pending_d = pending_q | req;
            cnt_d     = cnt_q + CNT_ONE;
            if (cnt_q == GUARD_LAST) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_ASSERT;
            cnt_d   = '0;
         end
      endcase

      cause_d   = (cause_clr ? 3'b000 : cause_q) | cause_set;
      rst_out_d = (state_d == ST_ASSERT) || (state_d == ST_HOLD);
      busy_d    = (state_d != ST_IDLE);
   end

   assign rst_out = rst_out_q;
   assign busy    = busy_q;
   assign cause   = cause_q;
   assign seq_cnt = seq_cnt_q;

endmodule

// File: tb/tb_ux607_reset_req_seq.sv
// Directed bench for ux607_reset_req_seq: pulse widths, cause/pending behaviour,
// asynchronous reset and seq_cnt saturation, all sampled on the falling edge.
module tb_ux607_reset_req_seq;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       req_sw = 1'b0;
   logic       req_wdt = 1'b0;
   logic       req_dbg = 1'b0;
   logic       hold_in = 1'b0;
   logic       cause_clr = 1'b0;
   logic       rst_out;
   logic       busy;
   logic [2:0] cause;
   logic [7:0] seq_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   ux607_reset_req_seq #(
      .ASSERT_CYCLES(20),
      .GUARD_CYCLES (4),
      .CNT_W        (8)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .req_sw   (req_sw),
      .req_wdt  (req_wdt),
      .req_dbg  (req_dbg),
      .hold_in  (hold_in),
      .cause_clr(cause_clr),
      .rst_out  (rst_out),
      .busy     (busy),
      .cause    (cause),
      .seq_cnt  (seq_cnt)
   );

   // Counts consecutive falling-edge samples with rst_out high; drops hold_in
   // after drop_at samples. Bounded so a stuck output cannot hang the run.
   task automatic count_high(input int drop_at, output int n);
      n = 0;
      while (rst_out === 1'b1 && n < 500) begin
         n++;
         if (n == drop_at) hold_in = 1'b0;
         @(negedge clock);
      end
   endtask

   task automatic count_busy(output int n);
      n = 0;
      while (busy === 1'b1 && n < 500) begin
         n++;
         @(negedge clock);
      end
   endtask

   task automatic power_on(output int hi, output int bz);
      @(posedge clock);
      #1 reset = 1'b1;
      @(negedge clock);
      count_high(0, hi);
      count_busy(bz);
   endtask

   task automatic test_reset();
      int hi, bz;
      repeat (3) @(negedge clock);
      checks++; if (rst_out !== 1'b1) begin errors++; $display("FAIL reset_rst_out: got %b expected 1", rst_out); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b expected 1", busy); end
      checks++; if (cause !== 3'b000) begin errors++; $display("FAIL reset_cause: got %b expected 000", cause); end
      checks++; if (seq_cnt !== 8'd0) begin errors++; $display("FAIL reset_seq_cnt: got %0d expected 0", seq_cnt); end
      power_on(hi, bz);
      checks++; if (hi !== 21) begin errors++; $display("FAIL por_high: got %0d expected 21", hi); end
      checks++; if (bz !== 4) begin errors++; $display("FAIL por_guard: got %0d expected 4", bz); end
      checks++; if (rst_out !== 1'b0) begin errors++; $display("FAIL por_idle_rst: got %b expected 0", rst_out); end
      checks++; if (cause !== 3'b000) begin errors++; $display("FAIL por_cause: got %b expected 000", cause); end
      checks++; if (seq_cnt !== 8'd0) begin errors++; $display("FAIL por_seq_cnt: got %0d expected 0", seq_cnt); end
      $display("txn power_on: high=%0d guard=%0d", hi, bz);
   endtask

   task automatic test_wdt_hold();
      int hi, bz;
      req_wdt = 1'b1;
      hold_in = 1'b1;
      @(negedge clock);
      req_wdt = 1'b0;
      count_high(30, hi);
      count_busy(bz);
      checks++; if (hi !== 30) begin errors++; $display("FAIL wdt_hold_high: got %0d expected 30", hi); end
      checks++; if (bz !== 4) begin errors++; $display("FAIL wdt_hold_guard: got %0d expected 4", bz); end
      checks++; if (cause !== 3'b010) begin errors++; $display("FAIL wdt_cause: got %b expected 010", cause); end
      checks++; if (seq_cnt !== 8'd1) begin errors++; $display("FAIL wdt_seq_cnt: got %0d expected 1", seq_cnt); end
      $display("txn wdt_hold: high=%0d guard=%0d cause=%b seq=%0d", hi, bz, cause, seq_cnt);
   endtask

   task automatic test_absorb();
      int hi, bz;
      req_sw = 1'b1;
      @(negedge clock);
      req_sw = 1'b0;
      checks++; if ({rst_out, busy} !== 2'b11) begin errors++; $display("FAIL absorb_first_cycle: got %b expected 11", {rst_out, busy}); end
      repeat (4) @(negedge clock);
      checks++; if (cause !== 3'b001) begin errors++; $display("FAIL absorb_cause_before: got %b expected 001", cause); end
      req_dbg = 1'b1;
      @(negedge clock);
      req_dbg = 1'b0;
      checks++; if (cause !== 3'b101) begin errors++; $display("FAIL absorb_cause_after: got %b expected 101", cause); end
      count_high(0, hi);
      hi = hi + 5;
      count_busy(bz);
      checks++; if (hi !== 21) begin errors++; $display("FAIL absorb_high: got %0d expected 21", hi); end
      checks++; if (bz !== 4) begin errors++; $display("FAIL absorb_guard: got %0d expected 4", bz); end
      checks++; if (seq_cnt !== 8'd1) begin errors++; $display("FAIL absorb_seq_cnt: got %0d expected 1", seq_cnt); end
      $display("txn absorb: high=%0d cause=%b seq=%0d", hi, cause, seq_cnt);
   endtask

   task automatic test_pending();
      int hi, bz;
      req_sw = 1'b1;
      @(negedge clock);
      req_sw = 1'b0;
      count_high(0, hi);
      checks++; if (hi !== 21) begin errors++; $display("FAIL pend_first_high: got %0d expected 21", hi); end
      @(negedge clock);
      req_sw = 1'b1;
      @(negedge clock);
      req_sw = 1'b0;
      count_busy(bz);
      checks++; if (bz !== 2) begin errors++; $display("FAIL pend_guard_rest: got %0d expected 2", bz); end
      checks++; if ({rst_out, busy} !== 2'b00) begin errors++; $display("FAIL pend_idle_gap: got %b expected 00", {rst_out, busy}); end
      @(negedge clock);
      count_high(0, hi);
      count_busy(bz);
      checks++; if (hi !== 21) begin errors++; $display("FAIL pend_second_high: got %0d expected 21", hi); end
      checks++; if (bz !== 4) begin errors++; $display("FAIL pend_second_guard: got %0d expected 4", bz); end
      checks++; if (seq_cnt !== 8'd2) begin errors++; $display("FAIL pend_seq_cnt: got %0d expected 2", seq_cnt); end
      checks++; if (cause !== 3'b001) begin errors++; $display("FAIL pend_cause: got %b expected 001", cause); end
      $display("txn pending: second_high=%0d seq=%0d", hi, seq_cnt);
   endtask

   task automatic test_cause_clr();
      int hi, bz;
      cause_clr = 1'b1;
      req_wdt   = 1'b1;
      @(negedge clock);
      cause_clr = 1'b0;
      req_wdt   = 1'b0;
      checks++; if (cause !== 3'b010) begin errors++; $display("FAIL clr_and_set: got %b expected 010", cause); end
      count_high(0, hi);
      count_busy(bz);
      cause_clr = 1'b1;
      @(negedge clock);
      cause_clr = 1'b0;
      checks++; if (cause !== 3'b000) begin errors++; $display("FAIL clr_only: got %b expected 000", cause); end
      checks++; if (seq_cnt !== 8'd3) begin errors++; $display("FAIL clr_seq_cnt: got %0d expected 3", seq_cnt); end
      $display("txn cause_clr: cause=%b seq=%0d", cause, seq_cnt);
   endtask

   task automatic test_reset_mid();
      int hi, bz;
      req_sw  = 1'b1;
      hold_in = 1'b1;
      @(negedge clock);
      req_sw = 1'b0;
      repeat (25) @(negedge clock);
      #2 reset = 1'b0;
      #1;
      checks++; if ({rst_out, busy} !== 2'b11) begin errors++; $display("FAIL mid_hold_outputs: got %b expected 11", {rst_out, busy}); end
      checks++; if (cause !== 3'b000) begin errors++; $display("FAIL mid_hold_cause: got %b expected 000", cause); end
      checks++; if (seq_cnt !== 8'd0) begin errors++; $display("FAIL mid_hold_seq_cnt: got %0d expected 0", seq_cnt); end
      hold_in = 1'b0;
      repeat (2) @(negedge clock);
      power_on(hi, bz);
      checks++; if (hi !== 21) begin errors++; $display("FAIL mid_hold_por_high: got %0d expected 21", hi); end
      checks++; if (bz !== 4) begin errors++; $display("FAIL mid_hold_por_guard: got %0d expected 4", bz); end
      checks++; if (seq_cnt !== 8'd0) begin errors++; $display("FAIL mid_hold_por_seq: got %0d expected 0", seq_cnt); end
      req_sw = 1'b1;
      @(negedge clock);
      req_sw = 1'b0;
      count_high(0, hi);
      #2 reset = 1'b0;
      #1;
      checks++; if (rst_out !== 1'b1) begin errors++; $display("FAIL guard_async_rst: got %b expected 1", rst_out); end
      repeat (2) @(negedge clock);
      power_on(hi, bz);
      $display("txn reset_mid: por_high=%0d por_guard=%0d", hi, bz);
   endtask

   task automatic test_saturate();
      int hi, bz;
      for (int i = 1; i <= 256; i++) begin
         req_sw = 1'b1;
         @(negedge clock);
         req_sw = 1'b0;
         count_high(0, hi);
         count_busy(bz);
         if (i == 255) begin
            checks++; if (seq_cnt !== 8'd255) begin errors++; $display("FAIL sat_255: got %0d expected 255", seq_cnt); end
         end
         if (i == 256) begin
            checks++; if (seq_cnt !== 8'd255) begin errors++; $display("FAIL sat_256: got %0d expected 255", seq_cnt); end
         end
      end
      $display("txn saturate: seq=%0d", seq_cnt);
   endtask

   initial begin
      test_reset();
      test_wdt_hold();
      reset = 1'b0;
      repeat (2) @(negedge clock);
      begin
         int hi, bz;
         power_on(hi, bz);
      end
      test_absorb();
      reset = 1'b0;
      repeat (2) @(negedge clock);
      begin
         int hi, bz;
         power_on(hi, bz);
      end
      test_pending();
      test_cause_clr();
      test_reset_mid();
      test_saturate();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
